fpro_mmio_arbiter: RTL and testbench
====================================

// Module: fpro_mmio_arbiter
// PURPOSE
//  Two-master arbiter for the FPRO MMIO bus. It sits between two bus masters and the MMIO controller:
//   - master 0: CPU bridge
//   - master 1: debug/DMA bridge
//  Round-robin arbitration serialises whole transactions and drives registered cs/rd/wr strobes.
//  Supports optional wait cycles for slow slots, and returns a one-cycle ack with registered read data.
// PARAMETERS
//  ADDR_W       21  MMIO word-address width (slot in [10:5], register in [4:0])
//  DATA_W       32  MMIO data width
//  WAIT_CYCLES  0   extra cycles cs/addr are held after the strobe cycle; legal range 0..15
// PORTS
//  clk           in   1       system clock
//  reset         in   1       asynchronous, active-low reset
//  m0_req        in   1       master 0 transaction request; held high until m0_ack
//  m0_wr         in   1       master 0: 1 = write, 0 = read
//  m0_addr       in   ADDR_W  master 0 address
//  m0_wr_data    in   DATA_W  master 0 write data
//  m0_ack        out  1       master 0 one-cycle completion pulse
//  m0_rd_data    out  DATA_W  master 0 read data; valid while m0_ack=1, then held
//  m1_*          -    -       identical set of six ports for master 1
//  mmio_cs       out  1       bus chip select
//  mmio_wr       out  1       bus write strobe
//  mmio_rd       out  1       bus read strobe
//  mmio_addr     out  ADDR_W  bus address
//  mmio_wr_data  out  DATA_W  bus write data
//  mmio_rd_data  in   DATA_W  bus read data (combinational from the slot mux)
//  grant_id      out  1       master owning the current or most recent transaction
//  busy          out  1       1 in every state except IDLE
// BEHAVIOUR
//  Reset (reset=0, asynchronous):
//   - All outputs go to 0; FSM goes to IDLE; wait counter cleared.
//   - Round-robin pointer last_grant=1, so master 0 wins the first contention.
//   - Reset asserted mid-transaction aborts it: no ack, and strobes drop immediately.
//  FSM states: IDLE -> ACCESS -> DONE -> IDLE. All outputs are registered.
//  IDLE:
//   - Requests are sampled only in this state.
//   - Single request: that master wins. Both requesting: the master != last_grant wins.
//   - On the grant edge: latch the winner's wr/addr/wr_data onto mmio_addr/mmio_wr_data; set grant_id and last_grant.
//   - Drive mmio_cs=1, mmio_wr=wr, mmio_rd=~wr for the first ACCESS cycle. Load wait counter with WAIT_CYCLES.
//  ACCESS, lasting WAIT_CYCLES+1 cycles:
//   - mmio_cs, mmio_addr and mmio_wr_data are held for every cycle.
//   - mmio_rd/mmio_wr are high in the FIRST ACCESS cycle only, so no duplicate FIFO pops or writes.
//   - In the LAST ACCESS cycle (counter==0): for a read, capture mmio_rd_data into the granted mX_rd_data register.
//   - On the exit edge: mmio_cs=0, mX_ack=1 for the granted master; go to DONE.
//  DONE: exactly one cycle, mX_ack=1, then ack clears and FSM returns to IDLE.
//  Latency and throughput:
//   - Request sampled at IDLE edge T -> strobe cycle T+1 -> ack cycle T+2+WAIT_CYCLES.
//   - Back-to-back throughput: one transaction per 3+WAIT_CYCLES cycles.
//  Handshake and data rules:
//   - A master must drop req in the cycle after its ack. If req is still high in IDLE, it is a new transaction.
//   - A request arriving while busy waits; it is never lost as long as req is held.
//   - Changing addr/data while req is held and not yet granted is legal. Values are taken at the grant edge.
//   - mX_rd_data changes only on that master's read completions; writes leave it unchanged.
//   - Exactly one ack per granted transaction; never to both masters in the same cycle.
//   - Both reqs in the DONE cycle: ignored until IDLE, then round-robin applies.
//  Counter: 4 bits, decrements in ACCESS; WAIT_CYCLES=0 means a single ACCESS cycle.
// TESTING
//  1. Reset: hold reset=0 with both reqs high -> all outputs 0. Release -> m0 granted first, grant_id=0, strobe 1 cycle later.
//  2. Single read, W=0: m0 reads 0x00021, slot returns 0xDEADBEEF.
//     -> mmio_rd high 1 cycle; m0_ack 2 cycles after req sample; m0_rd_data=0xDEADBEEF.
//  3. Contention: both masters hold req for 4 transactions -> grants alternate 0,1,0,1; a transaction every 3 cycles; no double ack.
//  4. W=3: m1 writes 0x12345678 to 0x00045 -> mmio_cs high 4 cycles, mmio_wr high first cycle only; m1_ack at cycle T+5.
//  5. Reset mid-ACCESS (W=3, 2nd cycle) -> cs/rd drop asynchronously; no ack after release; the next req completes normally.
//  6. Held req: m0 keeps req high after ack -> second transaction issued; m0_rd_data unchanged by an intervening m1 write.

Source files
------------

// File: rtl/fpro_mmio_arbiter.sv
// Two-master round-robin arbiter for the FPRO MMIO bus. Serialises whole
// transactions, drives registered cs/rd/wr strobes and returns a one-cycle ack.
module fpro_mmio_arbiter #(
   parameter int ADDR_W      = 21,
   parameter int DATA_W      = 32,
   parameter int WAIT_CYCLES = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_req,
   input  logic              m0_wr,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wr_data,
   output logic              m0_ack,
   output logic [DATA_W-1:0] m0_rd_data,
   input  logic              m1_req,
   input  logic              m1_wr,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wr_data,
   output logic              m1_ack,
   output logic [DATA_W-1:0] m1_rd_data,
   output logic              mmio_cs,
   output logic              mmio_wr,
   output logic              mmio_rd,
   output logic [ADDR_W-1:0] mmio_addr,
   output logic [DATA_W-1:0] mmio_wr_data,
   input  logic [DATA_W-1:0] mmio_rd_data,
   output logic              grant_id,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

   state_t            state, state_nxt;
   logic              last_grant;
   logic              txn_wr;
   logic [3:0]        cnt;
   logic              any_req;
   logic              win;
   logic              win_wr;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_data;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Under contention the master that did not own the last transaction wins.
   always_comb begin
      state_nxt = state;
      any_req   = m0_req | m1_req;
      win       = (m0_req & m1_req) ? ~last_grant : m1_req;
      win_wr    = win ? m1_wr      : m0_wr;
      win_addr  = win ? m1_addr    : m0_addr;
      win_data  = win ? m1_wr_data : m0_wr_data;
      case (state)
         IDLE:    if (any_req) state_nxt = ACCESS;
         ACCESS:  if (cnt == 4'd0) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_grant   <= 1'b1;
         grant_id     <= 1'b0;
         txn_wr       <= 1'b0;
         cnt          <= 4'd0;
         busy         <= 1'b0;
         mmio_cs      <= 1'b0;
         mmio_wr      <= 1'b0;
         mmio_rd      <= 1'b0;
         mmio_addr    <= '0;
         mmio_wr_data <= '0;
         m0_ack       <= 1'b0;
         m1_ack       <= 1'b0;
         m0_rd_data   <= '0;
         m1_rd_data   <= '0;
      end else begin
         busy <= (state_nxt != IDLE);
         case (state)
            IDLE: begin
               if (any_req) begin
                  grant_id     <= win;
                  last_grant   <= win;
                  txn_wr       <= win_wr;
                  mmio_addr    <= win_addr;
                  mmio_wr_data <= win_data;
                  mmio_cs      <= 1'b1;
                  mmio_wr      <= win_wr;
                  mmio_rd      <= ~win_wr;
                  cnt          <= 4'(WAIT_CYCLES);
               end
            end
            ACCESS: begin
               // Strobes last one cycle so slot FIFOs see a single pop/push.
               mmio_wr <= 1'b0;
               mmio_rd <= 1'b0;
               if (cnt == 4'd0) begin
                  mmio_cs <= 1'b0;
                  m0_ack  <= ~grant_id;
                  m1_ack  <= grant_id;
                  if (!txn_wr) begin
                     if (grant_id) m1_rd_data <= mmio_rd_data;
                     else          m0_rd_data <= mmio_rd_data;
                  end
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            DONE: begin
               m0_ack <= 1'b0;
               m1_ack <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fpro_mmio_arbiter.sv
// Bench for fpro_mmio_arbiter: two instances (WAIT_CYCLES 0 and 3) on one clock,
// a small slot memory per instance, and a bus monitor fed by a scoreboard queue.
module tb_fpro_mmio_arbiter;

   logic        clk = 1'b0;
   logic        rst_n        [2];
   logic        m0_req       [2];
   logic        m0_wr        [2];
   logic [20:0] m0_addr      [2];
   logic [31:0] m0_wr_data   [2];
   logic        m0_ack       [2];
   logic [31:0] m0_rd_data   [2];
   logic        m1_req       [2];
   logic        m1_wr        [2];
   logic [20:0] m1_addr      [2];
   logic [31:0] m1_wr_data   [2];
   logic        m1_ack       [2];
   logic [31:0] m1_rd_data   [2];
   logic        mmio_cs      [2];
   logic        mmio_wr      [2];
   logic        mmio_rd      [2];
   logic [20:0] mmio_addr    [2];
   logic [31:0] mmio_wr_data [2];
   logic [31:0] mmio_rd_data [2];
   logic        grant_id     [2];
   logic        busy         [2];

   logic [31:0] mem0 [16];
   logic [31:0] mem1 [16];

   typedef struct {
      logic        mst;
      logic        wr;
      logic [20:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } exp_t;

   typedef struct {
      int          inst;
      logic        mst;
      logic        wr;
      logic [20:0] addr;
      logic [31:0] wdata;
      logic [31:0] rexp;
   } vec_t;

   exp_t        q0[$];
   exp_t        q1[$];
   exp_t        cur     [2];
   bit          cur_v   [2];
   bit          prev_cs [2];
   int          cs_cnt  [2];
   int          acks    [2];
   logic [31:0] last_rd [2][2];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fpro_mmio_arbiter #(.ADDR_W(21), .DATA_W(32), .WAIT_CYCLES(0)) u_w0 (
      .clk(clk), .reset(rst_n[0]),
      .m0_req(m0_req[0]), .m0_wr(m0_wr[0]), .m0_addr(m0_addr[0]), .m0_wr_data(m0_wr_data[0]),
      .m0_ack(m0_ack[0]), .m0_rd_data(m0_rd_data[0]),
      .m1_req(m1_req[0]), .m1_wr(m1_wr[0]), .m1_addr(m1_addr[0]), .m1_wr_data(m1_wr_data[0]),
      .m1_ack(m1_ack[0]), .m1_rd_data(m1_rd_data[0]),
      .mmio_cs(mmio_cs[0]), .mmio_wr(mmio_wr[0]), .mmio_rd(mmio_rd[0]), .mmio_addr(mmio_addr[0]),
      .mmio_wr_data(mmio_wr_data[0]), .mmio_rd_data(mmio_rd_data[0]),
      .grant_id(grant_id[0]), .busy(busy[0]));

   fpro_mmio_arbiter #(.ADDR_W(21), .DATA_W(32), .WAIT_CYCLES(3)) u_w3 (
      .clk(clk), .reset(rst_n[1]),
      .m0_req(m0_req[1]), .m0_wr(m0_wr[1]), .m0_addr(m0_addr[1]), .m0_wr_data(m0_wr_data[1]),
      .m0_ack(m0_ack[1]), .m0_rd_data(m0_rd_data[1]),
      .m1_req(m1_req[1]), .m1_wr(m1_wr[1]), .m1_addr(m1_addr[1]), .m1_wr_data(m1_wr_data[1]),
      .m1_ack(m1_ack[1]), .m1_rd_data(m1_rd_data[1]),
      .mmio_cs(mmio_cs[1]), .mmio_wr(mmio_wr[1]), .mmio_rd(mmio_rd[1]), .mmio_addr(mmio_addr[1]),
      .mmio_wr_data(mmio_wr_data[1]), .mmio_rd_data(mmio_rd_data[1]),
      .grant_id(grant_id[1]), .busy(busy[1]));

   // Slot model: combinational read, write on the strobe edge.
   assign mmio_rd_data[0] = mem0[mmio_addr[0][3:0]];
   assign mmio_rd_data[1] = mem1[mmio_addr[1][3:0]];

   always @(posedge clk) begin
      if (mmio_cs[0] && mmio_wr[0]) mem0[mmio_addr[0][3:0]] = mmio_wr_data[0];
      if (mmio_cs[1] && mmio_wr[1]) mem1[mmio_addr[1][3:0]] = mmio_wr_data[1];
   end

   function automatic int wc(input int i);
      return (i == 0) ? 0 : 3;
   endfunction

   function automatic logic [31:0] slave_rd(input int i, input logic [20:0] a);
      return (i == 0) ? mem0[a[3:0]] : mem1[a[3:0]];
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic fail(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s (cycle %0d)", nm, cyc);
   endtask

   task automatic sb_push(input int i, input exp_t e);
      if (i == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   function automatic int sb_size(input int i);
      return (i == 0) ? q0.size() : q1.size();
   endfunction

   task automatic sb_pop(input int i, output exp_t e);
      if (i == 0) e = q0.pop_front();
      else        e = q1.pop_front();
   endtask

   // Bus monitor: each strobe pops the next expected transaction, each ack retires it.
   task automatic mon(input int i);
      exp_t e;
      logic ack_m;
      if (!rst_n[i]) begin
         cur_v[i] = 0; prev_cs[i] = 0; cs_cnt[i] = 0;
         last_rd[i][0] = '0; last_rd[i][1] = '0;
         return;
      end
      if (m0_ack[i] && m1_ack[i]) fail("dual_ack");
      if (mmio_cs[i] && (mmio_rd[i] || mmio_wr[i])) begin
         chk("dup_strobe", 32'(prev_cs[i]), 32'd0);
         if (sb_size(i) == 0) fail("unexpected_strobe");
         else begin
            sb_pop(i, e);
            if (!e.wr) e.rdata = slave_rd(i, e.addr);
            chk("grant_id", 32'(grant_id[i]), 32'(e.mst));
            chk("bus_addr", 32'(mmio_addr[i]), 32'(e.addr));
            chk("bus_wr", 32'(mmio_wr[i]), 32'(e.wr));
            chk("bus_rd", 32'(mmio_rd[i]), 32'(!e.wr));
            if (e.wr) chk("bus_wr_data", mmio_wr_data[i], e.wdata);
            cur[i] = e; cur_v[i] = 1;
         end
      end
      if (mmio_cs[i]) cs_cnt[i]++;
      else if (prev_cs[i]) begin
         chk("cs_len", 32'(cs_cnt[i]), 32'(wc(i) + 1));
         cs_cnt[i] = 0;
      end
      prev_cs[i] = mmio_cs[i];
      if (m0_ack[i] || m1_ack[i]) begin
         acks[i]++;
         if (!cur_v[i]) fail("spurious_ack");
         else begin
            ack_m = m1_ack[i];
            chk("ack_master", 32'(ack_m), 32'(cur[i].mst));
            if (!cur[i].wr) last_rd[i][cur[i].mst] = cur[i].rdata;
            chk("m0_rd_data", m0_rd_data[i], last_rd[i][0]);
            chk("m1_rd_data", m1_rd_data[i], last_rd[i][1]);
            cur_v[i] = 0;
         end
      end
   endtask

   always @(negedge clk) begin
      mon(0);
      mon(1);
   end

   task automatic set_req(input int i, input logic m, input logic on, input logic wr,
                          input logic [20:0] a, input logic [31:0] d);
      if (m) begin
         m1_req[i] = on; m1_wr[i] = wr; m1_addr[i] = a; m1_wr_data[i] = d;
      end else begin
         m0_req[i] = on; m0_wr[i] = wr; m0_addr[i] = a; m0_wr_data[i] = d;
      end
   endtask

   task automatic wait_ack(input int i, input logic m, output int k);
      k = 0;
      while (k < 60) begin
         @(negedge clk);
         k++;
         if (m ? m1_ack[i] : m0_ack[i]) return;
      end
      fail("ack_timeout");
      k = -1;
   endtask

   task automatic do_txn(input int i, input logic m, input logic wr,
                         input logic [20:0] a, input logic [31:0] d, output int lat);
      exp_t e;
      e = '{mst: m, wr: wr, addr: a, wdata: d, rdata: 32'h0};
      sb_push(i, e);
      @(negedge clk);
      set_req(i, m, 1'b1, wr, a, d);
      wait_ack(i, m, lat);
      set_req(i, m, 1'b0, wr, a, d);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl [8];
      int   lat, k, seen, t_prev, base;
      exp_t e;

      tbl[0] = '{0, 1'b0, 1'b0, 21'h00021,  32'h0,        32'hDEADBEEF};
      tbl[1] = '{0, 1'b1, 1'b1, 21'h00023,  32'h0BADF00D, 32'h0};
      tbl[2] = '{0, 1'b1, 1'b0, 21'h00023,  32'h0,        32'h0BADF00D};
      tbl[3] = '{0, 1'b0, 1'b1, 21'h00400,  32'h11112222, 32'h0};
      tbl[4] = '{1, 1'b1, 1'b1, 21'h00045,  32'h12345678, 32'h0};
      tbl[5] = '{1, 1'b0, 1'b0, 21'h00045,  32'h0,        32'h12345678};
      tbl[6] = '{1, 1'b1, 1'b0, 21'h1FFFFF, 32'h0,        32'hA5A5000F};
      tbl[7] = '{0, 1'b0, 1'b0, 21'h1FFFFF, 32'h0,        32'hA5A5000F};

      for (int j = 0; j < 16; j++) begin
         mem0[j] = 32'hA5A50000 | 32'(j);
         mem1[j] = 32'hA5A50000 | 32'(j);
      end
      mem0[1] = 32'hDEADBEEF;
      for (int i = 0; i < 2; i++) begin
         rst_n[i] = 1'b0;
         set_req(i, 1'b0, 1'b0, 1'b0, 21'h0, 32'h0);
         set_req(i, 1'b1, 1'b0, 1'b0, 21'h0, 32'h0);
         cur_v[i] = 0; prev_cs[i] = 0; cs_cnt[i] = 0; acks[i] = 0;
      end

      // Reset held with both masters requesting: everything stays at zero.
      set_req(0, 1'b0, 1'b1, 1'b0, 21'h00008, 32'h0);
      set_req(0, 1'b1, 1'b1, 1'b0, 21'h00009, 32'h0);
      repeat (3) @(negedge clk);
      chk("rst_cs",      32'(mmio_cs[0]),      32'd0);
      chk("rst_rd",      32'(mmio_rd[0]),      32'd0);
      chk("rst_wr",      32'(mmio_wr[0]),      32'd0);
      chk("rst_addr",    32'(mmio_addr[0]),    32'd0);
      chk("rst_wr_data", mmio_wr_data[0],      32'd0);
      chk("rst_m0_ack",  32'(m0_ack[0]),       32'd0);
      chk("rst_m1_ack",  32'(m1_ack[0]),       32'd0);
      chk("rst_m0_rd",   m0_rd_data[0],        32'd0);
      chk("rst_m1_rd",   m1_rd_data[0],        32'd0);
      chk("rst_grant",   32'(grant_id[0]),     32'd0);
      chk("rst_busy",    32'(busy[0]),         32'd0);
      e = '{mst: 1'b0, wr: 1'b0, addr: 21'h00008, wdata: 32'h0, rdata: 32'h0};
      sb_push(0, e);
      e = '{mst: 1'b1, wr: 1'b0, addr: 21'h00009, wdata: 32'h0, rdata: 32'h0};
      sb_push(0, e);
      rst_n[0] = 1'b1;
      rst_n[1] = 1'b1;
      @(negedge clk);
      chk("first_strobe_cs", 32'(mmio_cs[0]),  32'd1);
      chk("first_grant",     32'(grant_id[0]), 32'd0);
      chk("first_busy",      32'(busy[0]),     32'd1);
      wait_ack(0, 1'b0, lat);
      m0_req[0] = 1'b0;
      wait_ack(0, 1'b1, lat);
      m1_req[0] = 1'b0;

      // Contention: grants alternate, one transaction every 3 cycles.
      for (int n = 0; n < 4; n++) begin
         e = '{mst: 1'(n % 2), wr: 1'b0, addr: (n % 2) ? 21'h0000C : 21'h00002,
               wdata: 32'h0, rdata: 32'h0};
         sb_push(0, e);
      end
      @(negedge clk);
      set_req(0, 1'b0, 1'b1, 1'b0, 21'h00002, 32'h0);
      set_req(0, 1'b1, 1'b1, 1'b0, 21'h0000C, 32'h0);
      seen = 0; k = 0; t_prev = 0;
      while (seen < 4 && k < 100) begin
         @(negedge clk);
         k++;
         if (m0_ack[0] || m1_ack[0]) begin
            if (seen > 0) chk("txn_interval", 32'(cyc - t_prev), 32'd3);
            t_prev = cyc;
            chk("rr_order", 32'(m1_ack[0]), 32'(seen % 2));
            seen++;
            if (seen == 3) m0_req[0] = 1'b0;
            if (seen == 4) m1_req[0] = 1'b0;
         end
      end
      if (seen < 4) fail("contention_timeout");
      m0_req[0] = 1'b0;
      m1_req[0] = 1'b0;

      // Single transactions on both wait settings.
      for (int v = 0; v < 8; v++) begin
         do_txn(tbl[v].inst, tbl[v].mst, tbl[v].wr, tbl[v].addr, tbl[v].wdata, lat);
         chk("ack_latency", 32'(lat), 32'(2 + wc(tbl[v].inst)));
         if (!tbl[v].wr)
            chk("vec_rd_data", tbl[v].mst ? m1_rd_data[tbl[v].inst] : m0_rd_data[tbl[v].inst],
                tbl[v].rexp);
      end

      // Reset in the second ACCESS cycle of a WAIT_CYCLES=3 read.
      e = '{mst: 1'b0, wr: 1'b0, addr: 21'h00003, wdata: 32'h0, rdata: 32'h0};
      sb_push(1, e);
      @(negedge clk);
      set_req(1, 1'b0, 1'b1, 1'b0, 21'h00003, 32'h0);
      k = 0;
      while (!mmio_cs[1] && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (!mmio_cs[1]) fail("abort_no_strobe");
      @(negedge clk);
      #2 rst_n[1] = 1'b0;
      #1;
      chk("abort_cs",   32'(mmio_cs[1]), 32'd0);
      chk("abort_rd",   32'(mmio_rd[1]), 32'd0);
      chk("abort_busy", 32'(busy[1]),    32'd0);
      m0_req[1] = 1'b0;
      base = acks[1];
      repeat (3) @(negedge clk);
      rst_n[1] = 1'b1;
      repeat (6) @(negedge clk);
      chk("abort_no_ack", 32'(acks[1]), 32'(base));
      do_txn(1, 1'b1, 1'b0, 21'h00045, 32'h0, lat);
      chk("post_abort_latency", 32'(lat), 32'd5);
      chk("post_abort_rd", m1_rd_data[1], 32'h12345678);

      // Held request: m0 re-issues, m1 write in between leaves m0_rd_data alone.
      e = '{mst: 1'b0, wr: 1'b0, addr: 21'h00007, wdata: 32'h0, rdata: 32'h0};
      sb_push(0, e);
      e = '{mst: 1'b1, wr: 1'b1, addr: 21'h00007, wdata: 32'hCAFEF00D, rdata: 32'h0};
      sb_push(0, e);
      e = '{mst: 1'b0, wr: 1'b0, addr: 21'h00007, wdata: 32'h0, rdata: 32'h0};
      sb_push(0, e);
      @(negedge clk);
      set_req(0, 1'b0, 1'b1, 1'b0, 21'h00007, 32'h0);
      wait_ack(0, 1'b0, lat);
      chk("held_first_rd", m0_rd_data[0], 32'hA5A50007);
      set_req(0, 1'b1, 1'b1, 1'b1, 21'h00007, 32'hCAFEF00D);
      wait_ack(0, 1'b1, lat);
      m1_req[0] = 1'b0;
      chk("held_rd_kept", m0_rd_data[0], 32'hA5A50007);
      wait_ack(0, 1'b0, lat);
      m0_req[0] = 1'b0;
      chk("held_second_rd", m0_rd_data[0], 32'hCAFEF00D);

      repeat (5) @(negedge clk);
      chk("sb_drained_w0", 32'(q0.size()), 32'd0);
      chk("sb_drained_w3", 32'(q1.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
